smart_tl_ctl: RTL and testbench



---
 rtl/smart_tl_ctl.sv | 120 ++++++++++++
 tb/tb_smart_tl_ctl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/smart_tl_ctl.sv
// Two-road traffic light controller: main road (MR) green by default,
// green extended under heavy MR traffic up to a hard maximum.
//
// Ports:
//   clk        rising-edge system clock
//   rst        synchronous, active-high reset (forces MR green, timer 0)
//   MR_cars    [7:0] cars queued on the main road, sampled every clock
//   MR_ctl     [2:0] MR lamps, one-hot {red, yellow, green}
//   SR_ctl     [2:0] SR lamps, one-hot {red, yellow, green}
//   dbg_state  [2:0] current state code   (only with TLC_DBG_EN)
//   dbg_timer  [7:0] current timer value  (only with TLC_DBG_EN)
//
// Optional feature macro: TLC_DBG_EN adds the dbg_state/dbg_timer ports.

module smart_tl_ctl #(
    parameter int unsigned PARAMETER    = 45,
    parameter int unsigned MR_GREEN_MIN = 20,
    parameter int unsigned MR_GREEN_MAX = 60,
    parameter int unsigned SR_GREEN     = 10,
    parameter int unsigned YELLOW       = 3,
    parameter int unsigned ALL_RED      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] MR_cars,
    output logic [2:0] MR_ctl,
    output logic [2:0] SR_ctl
`ifdef TLC_DBG_EN
    ,
    output logic [2:0] dbg_state,
    output logic [7:0] dbg_timer
`endif
);

    typedef enum logic [2:0] {
        MR_G = 3'd0,
        MR_Y = 3'd1,
        AR1  = 3'd2,
        SR_G = 3'd3,
        SR_Y = 3'd4,
        AR2  = 3'd5
    } state_t;

    localparam logic [2:0] LAMP_G = 3'b001;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b100;

    // A state lasting N cycles exits on the edge where timer == N-1.
    localparam logic [7:0] GMIN_END = 8'(MR_GREEN_MIN - 1);
    localparam logic [7:0] GMAX_END = 8'(MR_GREEN_MAX - 1);
    localparam logic [7:0] SRG_END  = 8'(SR_GREEN - 1);
    localparam logic [7:0] YEL_END  = 8'(YELLOW - 1);
    localparam logic [7:0] AR_END   = 8'(ALL_RED - 1);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [2:0] mr_ctl_q, mr_ctl_d;
    logic [2:0] sr_ctl_q, sr_ctl_d;
    logic       light;

    // 32-bit compare so thresholds of 256 and above mean "always light".
    assign light = 32'(MR_cars) < PARAMETER;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MR_G: begin
                if ((timer_q >= GMIN_END && light) || timer_q == GMAX_END)
                    state_d = MR_Y;
            end
            MR_Y: if (timer_q == YEL_END) state_d = AR1;
            AR1:  if (timer_q == AR_END)  state_d = SR_G;
            SR_G: if (timer_q == SRG_END) state_d = SR_Y;
            SR_Y: if (timer_q == YEL_END) state_d = AR2;
            AR2:  if (timer_q == AR_END)  state_d = MR_G;
            default: state_d = MR_G;
        endcase

        timer_d = (state_d != state_q) ? 8'd0 : timer_q + 8'd1;

        // Lamps are decoded from the next state so the registered
        // outputs line up with the registered state.
        mr_ctl_d = LAMP_R;
        sr_ctl_d = LAMP_R;
        unique case (state_d)
            MR_G: mr_ctl_d = LAMP_G;
            MR_Y: mr_ctl_d = LAMP_Y;
            SR_G: sr_ctl_d = LAMP_G;
            SR_Y: sr_ctl_d = LAMP_Y;
            default: begin
                mr_ctl_d = LAMP_R;
                sr_ctl_d = LAMP_R;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MR_G;
            timer_q  <= 8'd0;
            mr_ctl_q <= LAMP_G;
            sr_ctl_q <= LAMP_R;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            mr_ctl_q <= mr_ctl_d;
            sr_ctl_q <= sr_ctl_d;
        end
    end

    assign MR_ctl = mr_ctl_q;
    assign SR_ctl = sr_ctl_q;

`ifdef TLC_DBG_EN
    // State codes match the required debug encoding; both flops reset to 0.
    assign dbg_state = state_q;
    assign dbg_timer = timer_q;
`endif

endmodule

// File: tb/tb_smart_tl_ctl.sv
// Scoreboard bench for smart_tl_ctl: randomized and directed MR_cars
// stimulus against a phase/duration reference model.

module tb_smart_tl_ctl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] MR_cars = 8'd0;
    logic [2:0] MR_ctl;
    logic [2:0] SR_ctl;
`ifdef TLC_DBG_EN
    logic [2:0] dbg_state;
    logic [7:0] dbg_timer;
`endif

    smart_tl_ctl dut (
        .clk     (clk),
        .rst     (rst),
        .MR_cars (MR_cars),
        .MR_ctl  (MR_ctl),
        .SR_ctl  (SR_ctl)
`ifdef TLC_DBG_EN
        ,
        .dbg_state (dbg_state),
        .dbg_timer (dbg_timer)
`endif
    );

    always #5 clk = ~clk;

    localparam int THRESH = 45;
    localparam int G_MIN  = 20;
    localparam int G_MAX  = 60;

    // Phase order: MR green, MR yellow, all-red, SR green, SR yellow, all-red.
    int         dur_tab[6] = '{0, 3, 1, 10, 3, 1};
    logic [2:0] mr_tab[6]  = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] sr_tab[6]  = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    int checks = 0;
    int fails  = 0;

    // Model: current phase and how many cycles it has been shown so far.
    int m_p   = 0;
    int m_len = 1;

    logic [5:0] exp_q[$];
    bit         started = 0;

    int last_mr_green = 0;
    int last_sr_green = 0;

    function automatic bit phase_over(input logic [7:0] cars);
        if (m_p == 0)
            return (m_len >= G_MIN && int'(cars) < THRESH) || m_len == G_MAX;
        return m_len == dur_tab[m_p];
    endfunction

    task automatic cycle(input logic [7:0] cars, input logic r);
        @(negedge clk);
        MR_cars = cars;
        rst     = r;
        if (r) begin
            m_p   = 0;
            m_len = 1;
        end else if (phase_over(cars)) begin
            m_p   = (m_p + 1) % 6;
            m_len = 1;
        end else begin
            m_len = m_len + 1;
        end
        exp_q.push_back({mr_tab[m_p], sr_tab[m_p]});
        started = 1;
    endtask

    // Run until the model shows phase p with timer value t, bounded.
    task automatic drive_until(input int p, input int t,
                               input logic [7:0] cars);
        int k = 0;
        while (!(m_p == p && m_len == t + 1) && k < 400) begin
            cycle(cars, 1'b0);
            k++;
        end
        if (k >= 400) begin
            checks++;
            fails++;
            $display("FAIL wait_phase: phase %0d timer %0d not reached", p, t);
        end
    endtask

    task automatic check_len(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d cycles, want %0d", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per clock and checks lamp invariants.
    initial begin
        logic [5:0] exp;
        logic [2:0] prev_mr = 3'b000;
        logic [2:0] prev_sr = 3'b000;
        bit   seen_rst = 0;
        bit   r_at;
        int   mr_run = 0, sr_run = 0;
        bit   mr_cut = 1, sr_cut = 1;
        forever begin
            @(posedge clk);
            r_at = rst;
            #1;
            if (!started) continue;

            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard: output with no expectation");
            end else begin
                exp = exp_q.pop_front();
                if ({MR_ctl, SR_ctl} !== exp) begin
                    fails++;
                    $display("FAIL lamps: MR=%b SR=%b, want MR=%b SR=%b",
                             MR_ctl, SR_ctl, exp[5:3], exp[2:0]);
                end
            end

            checks++;
            if (!($onehot(MR_ctl) && $onehot(SR_ctl))) begin
                fails++;
                $display("FAIL onehot: MR=%b SR=%b", MR_ctl, SR_ctl);
            end

            checks++;
            if ((MR_ctl[0] | MR_ctl[1]) && (SR_ctl[0] | SR_ctl[1])) begin
                fails++;
                $display("FAIL conflict: MR=%b SR=%b", MR_ctl, SR_ctl);
            end

            if (seen_rst && !r_at &&
                ((MR_ctl[0] && !prev_mr[0]) || (SR_ctl[0] && !prev_sr[0]))) begin
                checks++;
                if (!(prev_mr == 3'b100 && prev_sr == 3'b100)) begin
                    fails++;
                    $display("FAIL clearance: prev MR=%b SR=%b, want 100/100",
                             prev_mr, prev_sr);
                end
            end

            if (r_at) begin
                mr_cut = 1;
                if (sr_run != 0) sr_cut = 1;
                seen_rst = 1;
            end
            if (MR_ctl == 3'b001) mr_run++;
            else if (mr_run != 0) begin
                if (!mr_cut) last_mr_green = mr_run;
                mr_run = 0;
                mr_cut = 0;
            end
            if (SR_ctl == 3'b001) sr_run++;
            else if (sr_run != 0) begin
                if (!sr_cut) last_sr_green = sr_run;
                sr_run = 0;
                sr_cut = 0;
            end

            prev_mr = MR_ctl;
            prev_sr = SR_ctl;
        end
    end

    initial begin
        // Reset, then light traffic: 20/3/1/10/3/1.
        cycle(8'd0, 1'b1);
        cycle(8'd0, 1'b1);
        repeat (100) cycle(8'd0, 1'b0);
        check_len("light_mr_green", last_mr_green, 20);
        check_len("light_sr_green", last_sr_green, 10);

        // Heavy traffic holds MR green to the maximum.
        repeat (160) cycle(8'd50, 1'b0);
        check_len("heavy_mr_green", last_mr_green, 60);
        check_len("heavy_sr_green", last_sr_green, 10);

        // Traffic drops at timer 30: green ends after 31 cycles.
        drive_until(0, 30, 8'd50);
        cycle(8'd10, 1'b0);
        repeat (20) cycle(8'd10, 1'b0);
        check_len("drop_at_30", last_mr_green, 31);

        // Exactly at threshold counts as heavy.
        drive_until(0, 19, 8'd50);
        cycle(8'd45, 1'b0);
        cycle(8'd10, 1'b0);
        repeat (5) cycle(8'd10, 1'b0);
        check_len("thresh_45", last_mr_green, 21);

        // One below threshold ends green at the minimum.
        drive_until(0, 19, 8'd50);
        cycle(8'd44, 1'b0);
        repeat (5) cycle(8'd10, 1'b0);
        check_len("thresh_44", last_mr_green, 20);

        // Reset held for 3 cycles from the middle of SR green.
        drive_until(3, 4, 8'd0);
        repeat (3) cycle(8'($urandom_range(0, 99)), 1'b1);
        repeat (60) cycle(8'd0, 1'b0);
        check_len("after_reset_mr", last_mr_green, 20);

        // Sweeps with slow and slower input changes.
        for (int c = 0; c < 50; c++) repeat (10) cycle(8'(c), 1'b0);
        for (int c = 0; c < 50; c++) repeat (60) cycle(8'(c), 1'b0);

        // Random traffic with occasional resets.
        begin
            logic [7:0] rc = 8'd0;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 19) == 0)
                    rc = 8'($urandom_range(0, 90));
                cycle(rc, ($urandom_range(0, 149) == 0));
            end
        end

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
